// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared select encodings, defaults and scoreboard width helper
package fwd_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam int REG_AW_DEF = 4;

  // Enough bits to hold the value MUL_LAT itself.
  function automatic int sb_cnt_w(input int mul_lat);
    return (mul_lat < 1) ? 1 : $clog2(mul_lat + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// rtl/fwd_hazard_unit_src_sel.sv - forwarding select and hazard terms for one decode source
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              fwd_en_i,
  input  logic              src_valid_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  input  logic              exe_wb_en_i,
  input  logic              exe_mem_r_en_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic              mem_wb_en_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic              wb_wb_en_i,
  input  logic              sb_busy_i,
  output logic [1:0]        sel_o,
  output logic              ld_use_o,
  output logic              oth_haz_o
);

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;

  assign exe_hit = exe_wb_en_i && (src_i == exe_dest_i);
  assign mem_hit = mem_wb_en_i && (src_i == mem_dest_i);
  assign wb_hit  = wb_wb_en_i  && (src_i == wb_dest_i);

  // Pick the youngest in-flight producer; MEM is younger than WB so it wins.
  always_comb begin
    sel_o = SEL_RF;
    if (fwd_en_i && src_valid_i) begin
      if (mem_hit)     sel_o = SEL_MEM;
      else if (wb_hit) sel_o = SEL_WB;
    end
  end

  // Split hazard into the load-use term and everything else so the top can tell them apart.
  // WB hits never stall: the register file writes on the falling edge.
  always_comb begin
    ld_use_o  = src_valid_i && fwd_en_i && exe_hit && exe_mem_r_en_i;
    oth_haz_o = src_valid_i && (sb_busy_i || (!fwd_en_i && (exe_hit || mem_hit)));
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects, load-use/stall hazards and multiplier scoreboard (optional FWD_HAZARD_PERF_EN counters)
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 3,
  parameter int MUL_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic                      exe_wb_en,
  input  logic                      exe_mem_r_en,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      mem_wb_en,
  input  logic [REG_AW-1:0]         wb_dest,
  input  logic                      wb_wb_en,
  input  logic                      mul_issue,
  input  logic [REG_AW-1:0]         mul_dest,
  output logic [2*NUM_SRC-1:0]      sel_src,
  output logic                      hazard,
`ifdef FWD_HAZARD_PERF_EN
  output logic [31:0]               stall_cycles,
  output logic [31:0]               loaduse_stalls,
`endif
  output logic                      mul_pending
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = sb_cnt_w(MUL_LAT);

  logic [CW-1:0]      cnt_q [NREG];
  logic [CW-1:0]      cnt_d [NREG];
  logic [NUM_SRC-1:0] sb_busy;
  logic [NUM_SRC-1:0] ld_use;
  logic [NUM_SRC-1:0] oth_haz;
  logic               pend;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign sb_busy[i] = |cnt_q[src_addr[i*REG_AW +: REG_AW]];

    fwd_src_sel #(
      .REG_AW(REG_AW)
    ) u_sel (
      .fwd_en_i      (fwd_en),
      .src_valid_i   (src_valid[i]),
      .src_i         (src_addr[i*REG_AW +: REG_AW]),
      .exe_dest_i    (exe_dest),
      .exe_wb_en_i   (exe_wb_en),
      .exe_mem_r_en_i(exe_mem_r_en),
      .mem_dest_i    (mem_dest),
      .mem_wb_en_i   (mem_wb_en),
      .wb_dest_i     (wb_dest),
      .wb_wb_en_i    (wb_wb_en),
      .sb_busy_i     (sb_busy[i]),
      .sel_o         (sel_src[2*i +: 2]),
      .ld_use_o      (ld_use[i]),
      .oth_haz_o     (oth_haz[i])
    );
  end

  assign hazard = (|ld_use) || (|oth_haz);

  // Age every pending entry; an accepted multiply re-arms its destination over the decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    if (mul_issue && !hazard) begin
      cnt_d[mul_dest] = CW'(MUL_LAT);
    end
  end

  // Scoreboard state; reset forgets all in-flight multiplies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Any multiply still in flight, from registered state only.
  always_comb begin
    pend = 1'b0;
    for (int r = 0; r < NREG; r++) pend = pend | (|cnt_q[r]);
  end

  assign mul_pending = pend;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] loaduse_stalls_q;
  logic        ld_only;

  assign ld_only = (|ld_use) && !(|oth_haz);

  // Saturating stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      loaduse_stalls_q <= '0;
    end else begin
      if (hazard && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (ld_only && (loaduse_stalls_q != 32'hFFFF_FFFF)) begin
        loaduse_stalls_q <= loaduse_stalls_q + 32'd1;
      end
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign loaduse_stalls = loaduse_stalls_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's 2-source MEM/WB forwarding selector; sits beside the ID/EXE stage boundary.
- Produces per-source forwarding selects for NUM_SRC operands, including the store-data operand.
- Adds load-use hazard detection, a forwarding-disable mode, and a per-register scoreboard for a fixed-latency multi-cycle multiplier.
- Drives the pipeline freeze (`hazard`) consumed by the IF/ID registers and the bubble insertion into ID/EXE.

Parameters:
- REG_AW, 4, register address width; register count = 2**REG_AW
- NUM_SRC, 3, number of decode source operands checked
- MUL_LAT, 3, multiplier cycles from issue until the result is visible via WB/register file (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
- src_addr  in  NUM_SRC*REG_AW  packed decode source register numbers; source i at [i*REG_AW +: REG_AW]
- src_valid  in  NUM_SRC  source i is actually read by the decoded instruction
- exe_dest  in  REG_AW  EXE-stage destination
- exe_wb_en  in  1  EXE-stage instruction writes back
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_dest  in  REG_AW  MEM-stage destination
- mem_wb_en  in  1  MEM-stage write-back enable
- wb_dest  in  REG_AW  WB-stage destination
- wb_wb_en  in  1  WB-stage write-back enable
- mul_issue  in  1  decoded instruction is a multiply
- mul_dest  in  REG_AW  multiply destination
- sel_src  out  2*NUM_SRC  packed per-source select: 00 register file, 01 MEM result, 10 WB result
- hazard  out  1  freeze IF/ID, bubble ID/EXE
- mul_pending  out  1  any scoreboard entry nonzero (registered state)

Behaviour:
- Select, per source i (combinational), evaluated in this order:
  - if !fwd_en or !src_valid[i]: 00
  - else if mem_wb_en && src==mem_dest: 01 (MEM has priority over WB)
  - else if wb_wb_en && src==wb_dest: 10
  - else: 00
- Hazard (combinational) = OR over valid sources of:
  - fwd_en=1: exe_wb_en && exe_mem_r_en && src==exe_dest (load-use, exactly one stall cycle).
  - fwd_en=0: (exe_wb_en && src==exe_dest) || (mem_wb_en && src==mem_dest). A WB match never stalls, because the register file writes on the falling edge.
  - Both modes: scoreboard count for src is nonzero.
- Scoreboard:
  - One counter per register, width $clog2(MUL_LAT+1).
  - Reset clears all counters asynchronously.
  - Each posedge, every nonzero counter decrements by 1.
  - If mul_issue && !hazard, cnt[mul_dest] <= MUL_LAT. Issue overrides the decrement of the same entry (WAW re-arm allowed).
  - mul_issue while hazard=1 is ignored; the instruction is held and re-presented.
  - A source equal to the same-cycle mul_dest is not a hazard; the counter is not yet set.
- mul_pending = |counters, derived from registers only.
- Reset values: counters 0, mul_pending 0. sel_src and hazard follow inputs immediately; with all counters 0 they depend only on pipeline inputs.
- Reset mid-operation: all pending multiplies are forgotten at once, and hazard drops unless a combinational cause remains.
- Changing fwd_en mid-stream takes effect in the same cycle; no state is associated with it.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and loaduse_stalls[31:0].
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
  - stall_cycles increments every cycle hazard=1.
  - loaduse_stalls increments in cycles where the load-use term alone is true.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - the select encodings SEL_RF=2'b00, SEL_MEM=2'b01, SEL_WB=2'b10;
  - the default REG_AW;
  - a function computing the scoreboard counter width.
- One natural sub-module, fwd_src_sel: single-source select plus per-source hazard term, instantiated NUM_SRC times via generate.
- The scoreboard stays in the top level.

Test Plan:
- fwd_en=1; src0=3, mem_dest=3 mem_wb_en=1; wb_dest=3 wb_wb_en=1 -> sel_src[1:0]=01; then mem_wb_en=0 -> 10; then src_valid[0]=0 -> 00, hazard=0.
- fwd_en=1; exe_dest=5 exe_wb_en=1 exe_mem_r_en=1; src1=5 -> hazard=1 that cycle; next cycle the load has moved to MEM (mem_dest=5) -> hazard=0, sel_src[3:2]=01.
- fwd_en=0; src0=7 matches exe_dest -> hazard=1; next cycle matches mem_dest -> hazard=1; then matches wb_dest -> hazard=0, sel=00.
- MUL_LAT=3; mul_issue, mul_dest=2 -> src0=2 gives hazard=1 for exactly 3 cycles after issue; mul_pending 1 for those 3 cycles, then 0.
- Re-issue mul_dest=2 when cnt=1 -> count reloads to 3. Attempt mul_issue while hazard=1 -> counter unchanged.
- Assert rst while cnt[2]=2 -> mul_pending=0 and hazard=0 immediately (asynchronous); with FWD_HAZARD_PERF_EN, stall_cycles=0.
